// File: rtl/map_ss_seq_if.sv
`timescale 1ns/1ps
// Signal bundle between the save-state sequencer, the system host side and the mapper ss port.
// master = sequencer, slave = host/mapper side.
interface map_ss_seq_if;
    logic       cmd_save;
    logic       cmd_load;
    logic       busy;
    logic       done;
    logic       err;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] out_dat;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] in_dat;
    logic       in_vld;
    logic       in_rdy;

    modport master (
        input  cmd_save, cmd_load, ss_rdat, out_rdy, in_dat, in_vld,
        output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, out_dat, out_vld, in_rdy
    );

    modport slave (
        output cmd_save, cmd_load, ss_rdat, out_rdy, in_dat, in_vld,
        input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, out_dat, out_vld, in_rdy
    );
endinterface

// File: rtl/map_ss_seq.sv
`timescale 1ns/1ps
// Save-state sequencer: streams the mapper save-state space to the host on save, writes it back on load.
// Define SS_SUM_EN to append (save) or verify (load) a two's-complement checksum byte.
module map_ss_seq #(
    parameter int SS_LEN    = 128,
    parameter int RD_SETTLE = 2
) (
    input  logic          clk,
    input  logic          map_rst,
    input  logic          m2,
    map_ss_seq_if.master  bus
);

    localparam logic [7:0] LAST_ADDR = 8'(SS_LEN - 1);
    localparam int         CNT_MAX   = (RD_SETTLE > 2) ? RD_SETTLE : 2;
    localparam int         CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(RD_SETTLE);
    localparam logic [CNT_W-1:0] WR_GUARD   = CNT_W'(2);

`ifdef SS_SUM_EN
    typedef enum logic [3:0] {IDLE, ARM, RD_WAIT, RD_PUSH, LD_POP, LD_WR, LD_HOLD, SUM, FIN} state_t;
    localparam state_t TAIL = SUM;
`else
    typedef enum logic [3:0] {IDLE, ARM, RD_WAIT, RD_PUSH, LD_POP, LD_WR, LD_HOLD, FIN} state_t;
    localparam state_t TAIL = FIN;
`endif

    state_t           state, state_nxt;
    logic [2:0]       m2_sync;
    logic             m2_fall;
    logic             mode_save;
    logic [7:0]       addr_q, wdat_q, odat_q, sum_q;
    logic [7:0]       sum_rd;
    logic [CNT_W-1:0] cnt_q;
    logic             last;
    logic             in_sum;

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) m2_sync <= '0;
        else         m2_sync <= {m2_sync[1:0], m2};
    end

    assign m2_fall = m2_sync[2] & ~m2_sync[1];
    assign last    = (addr_q == LAST_ADDR);
    assign sum_rd  = sum_q + odat_q;

`ifdef SS_SUM_EN
    logic       err_q;
    logic [7:0] sum_ld;
    assign sum_ld  = sum_q + bus.in_dat;
    assign in_sum  = (state == SUM);
    assign bus.err = err_q;
`else
    assign in_sum  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_save || bus.cmd_load) state_nxt = ARM;
            ARM:     if (m2_fall) state_nxt = mode_save ? RD_WAIT : LD_POP;
            RD_WAIT: if (cnt_q == SETTLE_CNT) state_nxt = RD_PUSH;
            RD_PUSH: if (bus.out_rdy) state_nxt = last ? TAIL : RD_WAIT;
            LD_POP:  if (bus.in_vld) state_nxt = LD_WR;
            // A fall seen before WR_GUARD cycles belongs to an m2 edge that preceded ss_we.
            LD_WR:   if (m2_fall && cnt_q >= WR_GUARD) state_nxt = LD_HOLD;
            LD_HOLD: state_nxt = last ? TAIL : LD_POP;
`ifdef SS_SUM_EN
            SUM:     if (mode_save ? bus.out_rdy : bus.in_vld) state_nxt = FIN;
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            mode_save <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            odat_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
`ifdef SS_SUM_EN
            err_q     <= 1'b0;
`endif
        end else begin
            cnt_q <= '0;
            case (state)
                IDLE: if (bus.cmd_save || bus.cmd_load) begin
                    mode_save <= bus.cmd_save;
                    sum_q     <= '0;
`ifdef SS_SUM_EN
                    err_q     <= 1'b0;
`endif
                end
                RD_WAIT: begin
                    if (cnt_q == SETTLE_CNT) odat_q <= bus.ss_rdat;
                    else                     cnt_q  <= cnt_q + CNT_W'(1);
                end
                RD_PUSH: if (bus.out_rdy) begin
                    sum_q <= sum_rd;
                    if (!last) addr_q <= addr_q + 8'd1;
`ifdef SS_SUM_EN
                    else       odat_q <= 8'd0 - sum_rd;
`endif
                end
                LD_POP: if (bus.in_vld) begin
                    wdat_q <= bus.in_dat;
                    sum_q  <= sum_q + bus.in_dat;
                end
                LD_WR:   cnt_q <= (cnt_q >= WR_GUARD) ? cnt_q : cnt_q + CNT_W'(1);
                LD_HOLD: if (!last) addr_q <= addr_q + 8'd1;
`ifdef SS_SUM_EN
                SUM: if (!mode_save && bus.in_vld) begin
                    sum_q <= sum_ld;
                    if (sum_ld != 8'd0) err_q <= 1'b1;
                end
`endif
                FIN: begin
                    addr_q <= '0;
                    wdat_q <= '0;
                    odat_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE) && (state != FIN);
    assign bus.done    = (state == FIN);
    assign bus.ss_act  = bus.busy;
    assign bus.ss_we   = (state == LD_WR) || (state == LD_HOLD);
    assign bus.ss_addr = addr_q;
    assign bus.ss_wdat = wdat_q;
    assign bus.out_dat = odat_q;
    assign bus.out_vld = (state == RD_PUSH) || (in_sum && mode_save);
    assign bus.in_rdy  = (state == LD_POP) || (in_sum && !mode_save);

endmodule

// File: tb/tb_map_ss_seq.sv
`timescale 1ns/1ps
// Directed bench for map_ss_seq: mapper model returns addr^8'h5A and captures writes on m2 falls.
module tb_map_ss_seq;
    localparam int SS_LEN    = 128;
    localparam int RD_SETTLE = 2;
`ifdef SS_SUM_EN
    localparam int N_STREAM  = SS_LEN + 1;
`else
    localparam int N_STREAM  = SS_LEN;
`endif

    logic clk     = 1'b0;
    logic map_rst = 1'b1;
    logic m2      = 1'b1;

    int checks   = 0;
    int failures = 0;

    map_ss_seq_if bus ();

    map_ss_seq #(.SS_LEN(SS_LEN), .RD_SETTLE(RD_SETTLE)) dut (
        .clk     (clk),
        .map_rst (map_rst),
        .m2      (m2),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always begin
        #27.3 m2 = 1'b0;
        #30.1 m2 = 1'b1;
    end

    // Mapper model
    logic [7:0] mem [SS_LEN];
    int         wr_cnt = 0;
    assign bus.ss_rdat = bus.ss_addr ^ 8'h5A;
    always @(negedge m2) begin
        if (bus.ss_act && bus.ss_we) begin
            mem[bus.ss_addr] <= bus.ss_wdat;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    // Continuous monitors
    int         done_cnt = 0, bad_busy = 0, overlap_cnt = 0, we_pulses = 0;
    int         bad_we_stable = 0, bad_we_span = 0, wr_last = 0, wr_at_rise = 0;
    logic       we_q = 1'b0;
    logic [7:0] addr_q = '0, wdat_q = '0;
    always @(negedge clk) begin
        wr_last <= wr_cnt;
        if (map_rst) begin
            we_q <= 1'b0;
        end else begin
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.done && bus.busy) bad_busy <= bad_busy + 1;
            if (bus.in_rdy && bus.out_vld) overlap_cnt <= overlap_cnt + 1;
            if (bus.ss_we && !we_q) begin
                we_pulses  <= we_pulses + 1;
                wr_at_rise <= wr_last;
            end
            if (bus.ss_we && we_q && (bus.ss_addr !== addr_q || bus.ss_wdat !== wdat_q))
                bad_we_stable <= bad_we_stable + 1;
            if (!bus.ss_we && we_q && wr_cnt != wr_at_rise + 1)
                bad_we_span <= bad_we_span + 1;
            we_q   <= bus.ss_we;
            addr_q <= bus.ss_addr;
            wdat_q <= bus.ss_wdat;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {1'b0, bus.busy, bus.done, bus.err, bus.ss_act, bus.ss_we, bus.out_vld,
                bus.in_rdy, bus.ss_addr, bus.ss_wdat, bus.out_dat};
    endfunction

    function automatic logic [7:0] load_byte(input int i, input bit corrupt);
        if (i < SS_LEN) return 8'(i * 3);
        return 8'hC0 + {7'd0, corrupt};
    endfunction

    logic [7:0] got[$];

    task automatic save_run(input bit rdy_toggle, input bit both_cmd);
        int d0, p0, last_acc, bad_gap, bad_stable, bad, tot;
        logic [7:0] prev_dat;
        logic       prev_hold;
        d0 = done_cnt; p0 = we_pulses;
        last_acc = -1; bad_gap = 0; bad_stable = 0; prev_hold = 1'b0; prev_dat = '0;
        got.delete();
        bus.cmd_save = 1'b1;
        bus.cmd_load = both_cmd;
        @(negedge clk);
        bus.cmd_save = 1'b0;
        bus.cmd_load = 1'b0;
        check("busy_after_cmd", {31'd0, bus.busy}, 1);
        check("err_clear_on_cmd", {31'd0, bus.err}, 0);
        for (int cyc = 0; cyc < 4000 && !bus.done; cyc++) begin
            bus.cmd_load = both_cmd && (cyc == 4);
            bus.out_rdy  = rdy_toggle ? ((cyc / 3) % 2 == 0) : 1'b1;
            if (prev_hold && bus.out_dat !== prev_dat) bad_stable++;
            if (bus.out_vld && bus.out_rdy) begin
                if (!rdy_toggle && last_acc >= 0 && got.size() < SS_LEN
                    && cyc - last_acc != RD_SETTLE + 2) bad_gap++;
                last_acc = cyc;
                got.push_back(bus.out_dat);
            end
            prev_hold = bus.out_vld && !bus.out_rdy;
            prev_dat  = bus.out_dat;
            @(negedge clk);
        end
        bus.cmd_load = 1'b0;
        check("save_done_seen", {31'd0, bus.done}, 1);
        bus.out_rdy = 1'b0;
        @(negedge clk);
        check("save_done_once", done_cnt - d0, 1);
        check("save_idle_after", {30'd0, bus.ss_act, bus.busy}, 0);
        check("save_count", got.size(), N_STREAM);
        check("save_hold_stable", bad_stable, 0);
        check("save_byte_gap", bad_gap, 0);
        check("save_no_we", we_pulses - p0, 0);
        bad = 0;
        for (int i = 0; i < SS_LEN; i++)
            if (i >= got.size() || got[i] !== (8'(i) ^ 8'h5A)) bad++;
        check("save_data", bad, 0);
        if (got.size() == N_STREAM) begin
            check("save_first", {24'd0, got[0]}, 32'h5A);
            check("save_last", {24'd0, got[SS_LEN-1]}, 32'h25);
`ifdef SS_SUM_EN
            tot = 0;
            foreach (got[i]) tot += got[i];
            check("save_csum", {24'd0, got[SS_LEN]}, 32'h40);
            check("save_sum_zero", tot % 256, 0);
`endif
        end
    endtask

    task automatic load_run(input int n, input bit corrupt, input int abort_at, input bit exp_err);
        int d0, p0, w0, idx, first_addr, bad;
        d0 = done_cnt; p0 = we_pulses; w0 = wr_cnt; idx = 0; first_addr = -1;
        bus.cmd_load = 1'b1;
        @(negedge clk);
        bus.cmd_load = 1'b0;
        for (int cyc = 0; cyc < 20000 && !bus.done; cyc++) begin
            if (idx == abort_at) break;
            if (bus.in_rdy && first_addr < 0) first_addr = int'(bus.ss_addr);
            bus.in_vld = (idx < n);
            bus.in_dat = load_byte(idx, corrupt);
            if (bus.in_rdy && bus.in_vld) idx++;
            @(negedge clk);
        end
        bus.in_vld = 1'b0;
        if (abort_at >= 0) return;
        check("load_done_seen", {31'd0, bus.done}, 1);
        @(negedge clk);
        check("load_done_once", done_cnt - d0, 1);
        check("load_first_addr", first_addr, 0);
        check("load_bytes_taken", idx, n);
        check("load_we_pulses", we_pulses - p0, SS_LEN);
        check("load_mapper_writes", wr_cnt - w0, SS_LEN);
        check("load_we_stable", bad_we_stable, 0);
        check("load_we_span_fall", bad_we_span, 0);
        check("load_err", {31'd0, bus.err}, {31'd0, exp_err});
        check("load_idle_after", {30'd0, bus.ss_act, bus.busy}, 0);
        bad = 0;
        for (int i = 0; i < SS_LEN; i++)
            if (mem[i] !== 8'(i * 3)) bad++;
        check("load_mem", bad, 0);
    endtask

    initial begin
        int d0;
        bus.cmd_save = 1'b0;
        bus.cmd_load = 1'b0;
        bus.out_rdy  = 1'b0;
        bus.in_dat   = '0;
        bus.in_vld   = 1'b0;

        @(negedge clk);
        check("reset_outputs", out_vec(), 0);
        map_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", out_vec(), 0);

        save_run(1'b0, 1'b0);
        save_run(1'b1, 1'b0);

        // Reset in the middle of a load
        load_run(SS_LEN, 1'b0, 40, 1'b0);
        check("busy_before_rst", {30'd0, bus.busy, bus.ss_act}, 3);
        check("addr_before_rst", {24'd0, bus.ss_addr}, 39);
        #2 map_rst = 1'b1;
        #1 check("rst_mid_load_outputs", out_vec(), 0);
        repeat (3) @(negedge clk);
        map_rst = 1'b0;
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        check("idle_after_rst", out_vec(), 0);

        load_run(N_STREAM, 1'b0, -1, 1'b0);
`ifdef SS_SUM_EN
        load_run(N_STREAM, 1'b1, -1, 1'b1);
`endif
        save_run(1'b0, 1'b1);

        check("vld_rdy_overlap", overlap_cnt, 0);
        check("done_while_busy", bad_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_ss_seq.md
# map_ss_seq

Save-state sequencer for the mapper save-state port. On a save command it walks the mapper's save-state register space and streams each byte to the host. On a load command it accepts host bytes and writes them back, honouring the mapper's negedge-m2 register capture. It sits between the system save-state/DMA logic and any mapper module's ss_act/ss_we/ss_addr/ss_rdat/cpu_dat port.

## Interface
Parameters:
- SS_LEN, default 128: number of save-state bytes, covering ss_addr 0..SS_LEN-1 (1..256).
- RD_SETTLE, default 2: clk cycles to wait after an ss_addr change before sampling ss_rdat.

Ports:
- clk  in  1  system clock; the only clock.
- map_rst  in  1  reset, asynchronous, active-high.
- m2  in  1  CPU M2, asynchronous to clk. Passed through a 2-flop synchroniser before use.
- cmd_save  in  1  one-cycle start pulse for a save; ignored while busy.
- cmd_load  in  1  one-cycle start pulse for a load; ignored while busy. If both pulses arrive together, save wins.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  load checksum mismatch, sticky until the next command (only with SS_SUM_EN).
- ss_act  out  1  save-state mode to the mapper.
- ss_we  out  1  write strobe to the mapper.
- ss_addr  out  8  save-state address.
- ss_wdat  out  8  write data, driven onto the mapper's cpu_dat in ss mode.
- ss_rdat  in  8  mapper read data.
- out_dat  out  8  save stream data to the host.
- out_vld  out  1  save stream valid.
- out_rdy  in  1  host ready for save stream.
- in_dat  in  8  load stream data from the host.
- in_vld  in  1  load stream valid.
- in_rdy  out  1  sequencer ready for load stream.

## Operation
- States: IDLE, ARM, RD_WAIT, RD_PUSH, LD_POP, LD_WR, LD_HOLD, SUM, FIN.
- IDLE: all outputs are 0, ss_addr is 0.
  - cmd_save: go to ARM with mode=save.
  - cmd_load: go to ARM with mode=load.
  - A command also clears err and the sum register.
- ARM: assert ss_act and hold it asserted until FIN. Wait one synchronised m2 falling edge so the mapper sees ss_act before any access.
  - Then go to RD_WAIT for save, or LD_POP for load.
- RD_WAIT: count RD_SETTLE cycles, then latch ss_rdat into out_dat and go to RD_PUSH.
- RD_PUSH: drive out_vld=1 and hold out_dat stable until out_rdy.
  - On the accepting cycle (out_vld & out_rdy):
    - sum += byte (mod 256).
    - If this is the last address, go to SUM if enabled, otherwise FIN.
    - Otherwise increment ss_addr and return to RD_WAIT.
- LD_POP: drive in_rdy=1. On in_vld & in_rdy, latch in_dat into ss_wdat, add it to sum, and go to LD_WR.
- LD_WR: assert ss_we and wait for a synchronised m2 falling edge, then go to LD_HOLD.
- LD_HOLD: keep ss_we and ss_wdat for one more clk, then deassert ss_we.
  - If this is the last address, go to SUM if enabled, otherwise FIN.
  - Otherwise increment ss_addr and go to LD_POP.
- FIN: drop ss_act, pulse done, return to IDLE.
- ss_addr is 8 bits wide and never wraps within a sequence; its last value is SS_LEN-1.
- ss_wdat and ss_addr are stable during every cycle ss_we is high.
- Mid-sequence map_rst: immediately forces IDLE.
  - ss_act, ss_we, out_vld and in_rdy go to 0.
  - err and done go to 0. No done pulse is issued.
- Host stall: no timeout. The sequencer waits indefinitely in RD_PUSH or LD_POP.

## Timing
- Reset values: every output is 0.
- m2 synchroniser latency is 2 clk, and fall detection adds 1 clk. The mapper-side write therefore lands on the real m2 edge and ss_we is still held ≥1 clk afterwards.
- Save latency: cmd_save to the first out_vld is ARM (≤ one m2 period + 3 clk) plus RD_SETTLE + 1 clk.
- Each later save byte with out_rdy held high takes RD_SETTLE + 2 clk.
- Load: one mapper write per m2 period at most.
- busy rises the cycle after the command and falls the same cycle done pulses.
- in_rdy and out_vld are never high together.

## Configuration
- SS_SUM_EN defined: after the last data byte, SUM state handles a checksum byte.
  - Save: one extra stream byte, out_dat = (~sum + 1) mod 256, so the bytes total 0.
  - Load: one extra byte is consumed with no mapper write; if the sum including that byte ≠ 0, err is set.
- SS_SUM_EN undefined: no SUM state, err is tied to 0, and the stream is exactly SS_LEN bytes.

## Test plan
- SS_LEN=128, mapper model returns addr^8'h5A, out_rdy=1, cmd_save -> 128 bytes 8'h5A..8'h25 in address order; done once; ss_act low after; with SS_SUM_EN a 129th byte makes the total 0.
- Load 128 bytes i*3 with in_vld=1 -> 128 ss_we pulses, each spanning an m2 fall, ss_wdat=i*3 at ss_addr=i; the mapper model register space matches.
- out_rdy toggled every 3 clk during save -> out_dat stable while out_vld & !out_rdy; no byte lost or duplicated.
- SS_SUM_EN, load with the last checksum byte corrupted by +1 -> err=1 after done; a subsequent cmd_save clears err.
- map_rst asserted at byte 40 of a load -> all outputs 0 asynchronously, no done; a fresh cmd_load restarts at ss_addr 0.
- cmd_save and cmd_load pulsed in the same cycle, then cmd_load repeated while busy -> the save sequence runs and both load pulses are ignored.
